isdu: RTL and testbench
=======================

ISDU -- requirements
Module: isdu

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 3, number of cycles each memory read or write is held (range 1..15).
REQ-002 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Run, input, 1, starts execution from Halted.
REQ-005 SHALL have port Continue, input, 1, releases a PAUSE.
REQ-006 SHALL have port Opcode, input, 4, IR[15:12].
REQ-007 SHALL have port IR_5, input, 1, the immediate-select bit.
REQ-008 SHALL have port BEN, input, 1, the registered branch enable from the datapath.
REQ-009 SHALL have ports LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED, output, 1 each, register load enables.
REQ-010 SHALL have ports GatePC, GateMDR, GateALU, GateMARMUX, output, 1 each, bus drivers, at most one high per cycle.
REQ-011 SHALL have ports PCMUX, ADDR2MUX, ALUK, output, 2 each, selects.
REQ-012 SHALL have ports DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, output, 1 each, selects.
REQ-013 SHALL have ports Mem_OE, Mem_WE, output, 1 each, active-high memory read and write strobes.

Function
REQ-014 Encodings: PCMUX 00=PC+1, 01=adder, 10=bus. ADDR2MUX 00=0, 01=off6, 10=off9, 11=off11. ALUK 00=ADD, 01=AND, 10=NOT, 11=PASS. ADDR1MUX 0=PC, 1=SR1. SR1MUX 0=IR[11:9], 1=IR[8:6]. DRMUX 0=R7, 1=IR[11:9]. SR2MUX 0=imm5, 1=SR2. MIO_EN 1=MDR loads from memory.
REQ-015 SHALL be a Moore FSM; outputs depend on state (plus IR_5 in ADD/AND); every output is 0 unless listed for the state.
REQ-016 Halted: idle; Run=1 -> FETCH.
REQ-017 FETCH: GatePC, LD_MAR, LD_PC (PCMUX=00) -> RD_I.
REQ-018 RD_I, RD_D (read waits): Mem_OE, MIO_EN each cycle; LD_MDR on the final cycle; held exactly MEM_WAIT cycles via a wait counter that is cleared on entry; exit RD_I -> LOAD_IR, RD_D -> LDR_WB.
REQ-019 LOAD_IR: GateMDR, LD_IR -> DECODE.
REQ-020 DECODE: LD_BEN; next state per Opcode: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR, 0110 LDR_A, 0111 STR_A, 1101 PAUSE; all others -> FETCH.
REQ-021 ADD, AND, NOT: SR1MUX=1, SR2MUX=~IR_5, ALUK per op, GateALU, DRMUX=1, LD_REG, LD_CC -> FETCH.
REQ-022 BR: no outputs; BEN=1 -> BR_T, else FETCH. BR_T: ADDR1MUX=0, ADDR2MUX=10, PCMUX=01, LD_PC -> FETCH.
REQ-023 JMP: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=01, LD_PC -> FETCH.
REQ-024 JSR: GatePC, DRMUX=0, LD_REG -> JSR_T. JSR_T: ADDR1MUX=0, ADDR2MUX=11, PCMUX=01, LD_PC -> FETCH.
REQ-025 LDR_A, STR_A: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR; LDR_A -> RD_D, STR_A -> STR_D.
REQ-026 LDR_WB: GateMDR, DRMUX=1, LD_REG, LD_CC -> FETCH.
REQ-027 STR_D: SR1MUX=0, ALUK=11, GateALU, LD_MDR, MIO_EN=0 -> WR. WR: Mem_WE for MEM_WAIT cycles -> FETCH.
REQ-028 PAUSE: LD_LED on the first cycle only; holds while Continue=0; Continue=1 -> PAUSE_REL; PAUSE_REL holds until Continue=0 -> FETCH (one PAUSE consumes one Continue pulse).
REQ-029 Run is ignored outside Halted; Continue is ignored outside PAUSE.

Reset
REQ-030 Reset=0 SHALL force Halted, clear the wait counter, and drive all outputs to 0 immediately, including mid-access.
REQ-031 Release SHALL take effect on the first rising Clk edge with Reset=1.

Structure
REQ-032 State enum, opcode constants, and PCMUX/ADDR2MUX/ALUK encodings SHALL live in package slc3_pkg.
REQ-033 The wait counter SHALL be sub-module wait_timer (start, done), sized $clog2(MEM_WAIT+1).

Verification
REQ-034 Reset, then Run=1 for 1 cycle: FETCH, then 3 RD_I cycles with Mem_OE=1, then LOAD_IR, then DECODE.
REQ-035 Opcode=0001, IR_5=1: ADD state with SR2MUX=0, ALUK=00, LD_REG=LD_CC=1; back to FETCH 1 cycle later.
REQ-036 Opcode=0000: BEN=0 -> FETCH with LD_PC=0; BEN=1 -> BR_T with PCMUX=01, ADDR2MUX=10.
REQ-037 Opcode=0111 with MEM_WAIT=3: STR_A, STR_D, then exactly 3 cycles Mem_WE=1, then FETCH; Mem_OE=0 throughout.
REQ-038 Opcode=1101: LD_LED pulses once; Continue held high for 5 cycles does not re-fetch; Continue=0 -> FETCH.
REQ-039 Reset=0 during the second RD_D cycle: outputs 0 before the next edge; Halted persists until Run.
REQ-040 Every cycle: at most one Gate* high; Mem_OE and Mem_WE never both high.

Source files
------------

// File: rtl/slc3_pkg.sv
// slc3_pkg: shared types for the ISDU control unit.
//   state_t    - FSM state encoding
//   OP_*       - instruction opcodes (IR[15:12])
//   pcmux_t / addr2mux_t / aluk_t - datapath select encodings
//   ctrl_t     - bundle of every control output
//   state_ctrl - Moore decode of one state into its control word
package slc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH, S_RD_I, S_LOAD_IR, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_T, S_JMP, S_JSR, S_JSR_T,
        S_LDR_A, S_STR_A, S_RD_D, S_LDR_WB, S_STR_D, S_WR,
        S_PAUSE, S_PAUSE_REL
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    typedef enum logic [1:0] {PC_PLUS1, PC_ADDER, PC_BUS}           pcmux_t;
    typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11}  addr2mux_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS}  aluk_t;

    typedef struct packed {
        logic      ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic      gate_pc, gate_mdr, gate_alu, gate_marmux;
        pcmux_t    pcmux;
        addr2mux_t addr2mux;
        aluk_t     aluk;
        logic      drmux, sr1mux, sr2mux, addr1mux, mio_en;
        logic      mem_oe, mem_we;
    } ctrl_t;

    function automatic logic is_wait(input state_t s);
        return (s == S_RD_I) || (s == S_RD_D) || (s == S_WR);
    endfunction

    // last:  this cycle is the final cycle of a memory wait
    // first: this cycle is the first cycle spent in PAUSE
    function automatic ctrl_t state_ctrl(input state_t s, input logic last,
                                         input logic ir5, input logic first);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1;
                c.pcmux   = PC_PLUS1;
            end
            S_RD_I, S_RD_D: begin
                c.mem_oe = 1'b1; c.mio_en = 1'b1; c.ld_mdr = last;
            end
            S_LOAD_IR: begin
                c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
            end
            S_DECODE: c.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                c.sr1mux   = 1'b1; c.sr2mux = ~ir5;
                c.aluk     = (s == S_ADD) ? ALU_ADD : (s == S_AND) ? ALU_AND : ALU_NOT;
                c.gate_alu = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            end
            S_BR_T: begin
                c.addr1mux = 1'b0; c.addr2mux = A2_OFF9; c.pcmux = PC_ADDER; c.ld_pc = 1'b1;
            end
            S_JMP: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = A2_ZERO;
                c.pcmux  = PC_ADDER; c.ld_pc = 1'b1;
            end
            S_JSR: begin
                c.gate_pc = 1'b1; c.drmux = 1'b0; c.ld_reg = 1'b1;
            end
            S_JSR_T: begin
                c.addr1mux = 1'b0; c.addr2mux = A2_OFF11; c.pcmux = PC_ADDER; c.ld_pc = 1'b1;
            end
            S_LDR_A, S_STR_A: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = A2_OFF6;
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
            end
            S_LDR_WB: begin
                c.gate_mdr = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            end
            S_STR_D: begin
                c.sr1mux = 1'b0; c.aluk = ALU_PASS; c.gate_alu = 1'b1;
                c.ld_mdr = 1'b1; c.mio_en = 1'b0;
            end
            S_WR:    c.mem_we = 1'b1;
            S_PAUSE: c.ld_led = first;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/isdu_if.sv
// isdu_if: instruction-side inputs and control outputs of the ISDU.
//   slave  - the ISDU itself (takes Run/Continue/Opcode/IR_5/BEN, drives controls)
//   master - whoever drives the ISDU inputs and consumes its controls
interface isdu_if;
    logic       Run, Continue, IR_5, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
    logic       Mem_OE, Mem_WE;

    modport slave (
        input  Run, Continue, Opcode, IR_5, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
               DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE
    );
    modport master (
        output Run, Continue, Opcode, IR_5, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
               DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/isdu_wait_timer.sv
// wait_timer: counts cycles spent in a memory wait state.
//   start    - clear the count (asserted whenever not continuing a wait)
//   done     - current cycle is the MEM_WAIT-th cycle of the wait
//   done_nxt - the cycle after this edge will be the final one
module wait_timer #(
    parameter int MEM_WAIT = 3
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    output logic done,
    output logic done_nxt
);
    localparam int W = $clog2(MEM_WAIT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_WAIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = start ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done     = (cnt_q == LAST);
    assign done_nxt = (cnt_d == LAST);
endmodule

// File: rtl/isdu.sv
// isdu: LC-3 style instruction sequencing and decode unit (Moore FSM).
//   Clk, Reset (async active-low), bus (isdu_if.slave): Run/Continue/Opcode/
//   IR_5/BEN in, register loads, bus gates, mux selects and memory strobes out.
// Control outputs are registered together with the state, decoded from the
// next state, so they change exactly when the state does and clear with Reset.
module isdu
    import slc3_pkg::*;
#(
    parameter int MEM_WAIT = 3
) (
    input  logic Clk,
    input  logic Reset,
    isdu_if.slave bus
);
    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   tmr_start, tmr_done, tmr_done_nxt, pause_first;

    wait_timer #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (tmr_start),
        .done     (tmr_done),
        .done_nxt (tmr_done_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALTED:  if (bus.Run) state_d = S_FETCH;
            S_FETCH:   state_d = S_RD_I;
            S_RD_I:    if (tmr_done) state_d = S_LOAD_IR;
            S_LOAD_IR: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_ADD:   state_d = S_ADD;
                    OP_AND:   state_d = S_AND;
                    OP_NOT:   state_d = S_NOT;
                    OP_BR:    state_d = S_BR;
                    OP_JMP:   state_d = S_JMP;
                    OP_JSR:   state_d = S_JSR;
                    OP_LDR:   state_d = S_LDR_A;
                    OP_STR:   state_d = S_STR_A;
                    OP_PAUSE: state_d = S_PAUSE;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_BR:        state_d = bus.BEN ? S_BR_T : S_FETCH;
            S_JSR:       state_d = S_JSR_T;
            S_LDR_A:     state_d = S_RD_D;
            S_RD_D:      if (tmr_done) state_d = S_LDR_WB;
            S_STR_A:     state_d = S_STR_D;
            S_STR_D:     state_d = S_WR;
            S_WR:        if (tmr_done) state_d = S_FETCH;
            S_PAUSE:     if (bus.Continue) state_d = S_PAUSE_REL;
            // Wait for Continue to drop so one pulse releases only one PAUSE
            S_PAUSE_REL: if (!bus.Continue) state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase

        // Counter restarts on every cycle that is not a continuation of a wait
        tmr_start   = !(is_wait(state_q) && (state_d == state_q));
        pause_first = (state_d == S_PAUSE) && (state_q != S_PAUSE);
        ctrl_d      = state_ctrl(state_d, tmr_done_nxt, bus.IR_5, pause_first);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_HALTED;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.LD_MAR     = ctrl_q.ld_mar;
    assign bus.LD_MDR     = ctrl_q.ld_mdr;
    assign bus.LD_IR      = ctrl_q.ld_ir;
    assign bus.LD_BEN     = ctrl_q.ld_ben;
    assign bus.LD_CC      = ctrl_q.ld_cc;
    assign bus.LD_REG     = ctrl_q.ld_reg;
    assign bus.LD_PC      = ctrl_q.ld_pc;
    assign bus.LD_LED     = ctrl_q.ld_led;
    assign bus.GatePC     = ctrl_q.gate_pc;
    assign bus.GateMDR    = ctrl_q.gate_mdr;
    assign bus.GateALU    = ctrl_q.gate_alu;
    assign bus.GateMARMUX = ctrl_q.gate_marmux;
    assign bus.PCMUX      = ctrl_q.pcmux;
    assign bus.ADDR2MUX   = ctrl_q.addr2mux;
    assign bus.ALUK       = ctrl_q.aluk;
    assign bus.DRMUX      = ctrl_q.drmux;
    assign bus.SR1MUX     = ctrl_q.sr1mux;
    assign bus.SR2MUX     = ctrl_q.sr2mux;
    assign bus.ADDR1MUX   = ctrl_q.addr1mux;
    assign bus.MIO_EN     = ctrl_q.mio_en;
    assign bus.Mem_OE     = ctrl_q.mem_oe;
    assign bus.Mem_WE     = ctrl_q.mem_we;
endmodule

// File: tb/tb_isdu.sv
// tb_isdu: directed, table-driven check of the ISDU control sequence with
// MEM_WAIT=3, plus a hand-written asynchronous reset during a data read.
module tb_isdu;
    logic Clk = 1'b0;
    logic Reset;
    isdu_if bus ();

    isdu #(.MEM_WAIT(3)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    // Observed control word, MSB first
    logic [24:0] obs;
    assign obs = {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_CC,
                  bus.LD_REG, bus.LD_PC, bus.LD_LED, bus.GatePC, bus.GateMDR,
                  bus.GateALU, bus.GateMARMUX, bus.PCMUX, bus.ADDR2MUX, bus.ALUK,
                  bus.DRMUX, bus.SR1MUX, bus.SR2MUX, bus.ADDR1MUX, bus.MIO_EN,
                  bus.Mem_OE, bus.Mem_WE};

    localparam logic [24:0] B_LDMAR = 25'h1 << 24, B_LDMDR = 25'h1 << 23,
        B_LDIR = 25'h1 << 22, B_LDBEN = 25'h1 << 21, B_LDCC = 25'h1 << 20,
        B_LDREG = 25'h1 << 19, B_LDPC = 25'h1 << 18, B_LDLED = 25'h1 << 17,
        B_GPC = 25'h1 << 16, B_GMDR = 25'h1 << 15, B_GALU = 25'h1 << 14,
        B_GMARMUX = 25'h1 << 13, B_PC01 = 25'h1 << 11, B_A2_01 = 25'h1 << 9,
        B_A2_10 = 25'h2 << 9, B_A2_11 = 25'h3 << 9, B_ALU01 = 25'h1 << 7,
        B_ALU10 = 25'h2 << 7, B_ALU11 = 25'h3 << 7, B_DRM = 25'h1 << 6,
        B_SR1 = 25'h1 << 5, B_SR2 = 25'h1 << 4, B_A1 = 25'h1 << 3,
        B_MIO = 25'h1 << 2, B_OE = 25'h1 << 1, B_WE = 25'h1;

    localparam logic [24:0] E_FETCH = B_LDMAR | B_GPC | B_LDPC;
    localparam logic [24:0] E_RD    = B_MIO | B_OE;
    localparam logic [24:0] E_RDL   = B_MIO | B_OE | B_LDMDR;
    localparam logic [24:0] E_LDIR  = B_GMDR | B_LDIR;
    localparam logic [24:0] E_DEC   = B_LDBEN;
    localparam logic [24:0] E_ALU   = B_SR1 | B_GALU | B_DRM | B_LDREG | B_LDCC;
    localparam logic [24:0] E_BRT   = B_PC01 | B_A2_10 | B_LDPC;
    localparam logic [24:0] E_JMP   = B_SR1 | B_A1 | B_PC01 | B_LDPC;
    localparam logic [24:0] E_JSR   = B_GPC | B_LDREG;
    localparam logic [24:0] E_JSRT  = B_A2_11 | B_PC01 | B_LDPC;
    localparam logic [24:0] E_MADR  = B_SR1 | B_A1 | B_A2_01 | B_GMARMUX | B_LDMAR;
    localparam logic [24:0] E_LDRWB = B_GMDR | B_DRM | B_LDREG | B_LDCC;
    localparam logic [24:0] E_STRD  = B_ALU11 | B_GALU | B_LDMDR;

    typedef struct {
        string       name;
        logic        run, cont;
        logic [3:0]  op;
        logic        ir5, ben;
        logic [24:0] exp;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string nm, input logic run, input logic cont,
                        input logic [3:0] op, input logic ir5, input logic ben,
                        input logic [24:0] exp);
        vec_t v;
        v.name = nm; v.run = run; v.cont = cont; v.op = op;
        v.ir5 = ir5; v.ben = ben; v.exp = exp;
        vq.push_back(v);
    endtask

    // The three instruction-read cycles, LOAD_IR and DECODE following a FETCH
    task automatic push_fetch(input logic run, input logic cont,
                              input logic [3:0] op, input logic ir5, input logic ben);
        push("rd_i0", run, cont, op, ir5, ben, E_RD);
        push("rd_i1", run, cont, op, ir5, ben, E_RD);
        push("rd_i2", run, cont, op, ir5, ben, E_RDL);
        push("ld_ir", run, cont, op, ir5, ben, E_LDIR);
        push("decode", run, cont, op, ir5, ben, E_DEC);
    endtask

    task automatic check(input string nm, input int idx, input logic [24:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", nm, idx, obs, exp);
        end
        checks++;
        if ($countones(obs[16:13]) > 1 || (obs[1] && obs[0])) begin
            errors++;
            $display("FAIL %s row %0d bus/strobe conflict: got %h want onehot0 gates, no OE&WE",
                     nm, idx, obs);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        bus.Run = v.run; bus.Continue = v.cont; bus.Opcode = v.op;
        bus.IR_5 = v.ir5; bus.BEN = v.ben;
        @(posedge Clk);
        #1;
        check(v.name, idx, v.exp);
    endtask

    initial begin
        Reset = 1'b0;
        bus.Run = 1'b0; bus.Continue = 1'b0; bus.Opcode = 4'h0;
        bus.IR_5 = 1'b0; bus.BEN = 1'b0;
        #12;
        check("reset", -1, '0);
        #5 Reset = 1'b1;

        // Main program
        push("halted", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, '0);
        push("fetch", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, E_FETCH);
        // ADD imm, with Continue toggling (ignored outside PAUSE)
        push_fetch(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
        push("add_i", 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, E_ALU);
        push("fetch", 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, E_FETCH);
        // ADD reg, with Run held high (ignored outside Halted)
        push_fetch(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
        push("add_r", 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, E_ALU | B_SR2);
        push("fetch", 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, E_FETCH);
        push_fetch(1'b0, 1'b0, 4'b0101, 1'b1, 1'b0);
        push("and_i", 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, E_ALU | B_ALU01);
        push("fetch", 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, E_FETCH);
        push_fetch(1'b0, 1'b0, 4'b1001, 1'b1, 1'b0);
        push("not", 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0, E_ALU | B_ALU10);
        push("fetch", 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0, E_FETCH);
        // BR not taken
        push_fetch(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        push("br_nt", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, '0);
        push("fetch", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, E_FETCH);
        // BR taken
        push_fetch(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        push("br", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, '0);
        push("br_t", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, E_BRT);
        push("fetch", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, E_FETCH);
        push_fetch(1'b0, 1'b0, 4'b1100, 1'b0, 1'b0);
        push("jmp", 1'b0, 1'b0, 4'b1100, 1'b0, 1'b0, E_JMP);
        push("fetch", 1'b0, 1'b0, 4'b1100, 1'b0, 1'b0, E_FETCH);
        push_fetch(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
        push("jsr", 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, E_JSR);
        push("jsr_t", 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, E_JSRT);
        push("fetch", 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, E_FETCH);
        // LDR: address, 3 data read cycles, writeback
        push_fetch(1'b0, 1'b0, 4'b0110, 1'b0, 1'b0);
        push("ldr_a", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, E_MADR);
        push("rd_d0", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, E_RD);
        push("rd_d1", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, E_RD);
        push("rd_d2", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, E_RDL);
        push("ldr_wb", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, E_LDRWB);
        push("fetch", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, E_FETCH);
        // STR: exactly three write cycles, no OE
        push_fetch(1'b0, 1'b0, 4'b0111, 1'b0, 1'b0);
        push("str_a", 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, E_MADR);
        push("str_d", 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, E_STRD);
        push("wr0", 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, B_WE);
        push("wr1", 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, B_WE);
        push("wr2", 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, B_WE);
        push("fetch", 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, E_FETCH);
        // Unassigned opcode falls straight back to FETCH
        push_fetch(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
        push("illegal", 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, E_FETCH);
        // PAUSE: single LED pulse, long Continue does not re-fetch
        push_fetch(1'b0, 1'b0, 4'b1101, 1'b0, 1'b0);
        push("pause1", 1'b0, 1'b0, 4'b1101, 1'b0, 1'b0, B_LDLED);
        push("pause", 1'b0, 1'b0, 4'b1101, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++)
            push("pause_rel", 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, '0);
        push("fetch", 1'b0, 1'b0, 4'b1101, 1'b0, 1'b0, E_FETCH);
        // Into the second data read cycle of an LDR for the reset test
        push_fetch(1'b0, 1'b0, 4'b0110, 1'b0, 1'b0);
        push("ldr_a", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, E_MADR);
        push("rd_d0", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, E_RD);
        push("rd_d1", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, E_RD);

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Asynchronous reset mid-access: outputs clear before the next edge
        #3 Reset = 1'b0;
        #1 check("rst_async", -2, '0);
        bus.Run = 1'b1;
        @(posedge Clk);
        #1 check("rst_hold", -3, '0);
        bus.Run = 1'b0;
        Reset = 1'b1;
        vq.delete();
        for (int i = 0; i < 3; i++)
            push("halt_persist", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, '0);
        push("fetch_rel", 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, E_FETCH);
        push("rd_i0_rel", 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, E_RD);
        for (int i = 0; i < vq.size(); i++) apply(vq[i], 1000 + i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
